dso_trigger_ctrl: RTL and testbench

Trigger and acquisition sequencer for the DSO datapath. Watches the ADC sample stream, runs the pre-trigger / armed / post-trigger sequence, and generates sample-buffer write strobes and addresses. Drives `t_int`, the single-bit acquisition-busy line read by the NIOS2 trigger-interrupt PIO, which interrupts on its falling edge. Configured and read back through an Avalon-MM slave on the NIOS2 bus.

---
 rtl/dso_pkg.sv | 27 ++
 rtl/dso_trig_cmp.sv | 34 +++
 rtl/dso_trigger_ctrl.sv | 157 +++++++++++++++
 tb/tb_dso_trigger_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared definitions for the DSO trigger controller: the register map, the CTRL
// bit positions and the acquisition state encoding.
package dso_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_LEVEL     = 3'd1;
  localparam logic [2:0] REG_PRE       = 3'd2;
  localparam logic [2:0] REG_POST      = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_TRIG_ADDR = 3'd5;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_SLOPE = 1;
  localparam int CTRL_AUTO  = 2;
  localparam int CTRL_FORCE = 3;
  localparam int CTRL_ABORT = 4;

  localparam int AUTO_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_ARMED = 2'd2,
    ST_POST  = 2'd3
  } state_t;

endpackage

// File: rtl/dso_trig_cmp.sv
// Slope and hysteresis comparator. It reports whether a sample primes the
// trigger and whether it fires the trigger, given the current primed flag.
module dso_trig_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] hyst,
  input  logic              slope,
  input  logic              primed,
  output logic              prime_set,
  output logic              fire
);
  logic [DATA_W:0]   lo_raw;
  logic [DATA_W:0]   hi_raw;
  logic [DATA_W-1:0] lo_thr;
  logic [DATA_W-1:0] hi_thr;

  // The extra top bit of the raw sums flags borrow and carry. Both limits saturate.
  always_comb begin
    lo_raw = {1'b0, level} - {1'b0, hyst};
    hi_raw = {1'b0, level} + {1'b0, hyst};
    lo_thr = lo_raw[DATA_W] ? '0 : lo_raw[DATA_W-1:0];
    hi_thr = hi_raw[DATA_W] ? '1 : hi_raw[DATA_W-1:0];
    if (slope) begin
      prime_set = (sample > hi_thr);
      fire      = primed && (sample <= level);
    end else begin
      prime_set = (sample < lo_thr);
      fire      = primed && (sample >= level);
    end
  end

endmodule

// File: rtl/dso_trigger_ctrl.sv
// DSO trigger and acquisition sequencer. It holds the Avalon-MM register file, runs
// the PRE/ARMED/POST sequence, drives the sample-buffer writes and the t_int busy line.
module dso_trigger_ctrl
  import dso_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int AUTO_TO = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic              t_int
);
  state_t            state, state_nx;
  logic [DATA_W-1:0] level, hyst;
  logic [ADDR_W-1:0] pre_len, post_len, seq_cnt, wr_ptr, trig_addr;
  logic [ADDR_W:0]   seq_inc;
  logic [AUTO_W-1:0] auto_cnt;
  logic              slope, auto_en, primed, force_pend, trig_auto;
  logic              reg_wr, reg_rd, ctrl_wr, arm_req, force_req, abort_req;
  logic              prime_set, fire, auto_expired, sample_wr, trig, trig_ok;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign reg_wr       = chipselect && !write_n;
  assign reg_rd       = chipselect && write_n;
  assign ctrl_wr      = reg_wr && (address == REG_CTRL);
  assign arm_req      = ctrl_wr && writedata[CTRL_ARM];
  assign force_req    = ctrl_wr && writedata[CTRL_FORCE];
  assign abort_req    = ctrl_wr && writedata[CTRL_ABORT];
  assign unused_wdata = ^writedata[31:16];

  assign sample_wr    = adc_valid && (state != ST_IDLE);
  assign seq_inc      = {1'b0, seq_cnt} + (ADDR_W+1)'(1);
  assign auto_expired = (auto_cnt >= AUTO_W'(AUTO_TO));
  assign trig         = (state == ST_ARMED) && adc_valid &&
                        (fire || force_pend || (auto_en && auto_expired));
  assign trig_ok      = trig && !abort_req;

  dso_trig_cmp #(.DATA_W(DATA_W)) u_cmp (
    .sample    (adc_data),
    .level     (level),
    .hyst      (hyst),
    .slope     (slope),
    .primed    (primed),
    .prime_set (prime_set),
    .fire      (fire)
  );

  // NOTE: every combinational output is given a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arm_req) state_nx = (pre_len == '0) ? ST_ARMED : ST_PRE;
      ST_PRE:   if (adc_valid && (seq_inc >= {1'b0, pre_len})) state_nx = ST_ARMED;
      ST_ARMED: if (trig) state_nx = (post_len == '0) ? ST_IDLE : ST_POST;
      ST_POST:  if (adc_valid && (seq_inc >= {1'b0, post_len})) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (abort_req) state_nx = ST_IDLE;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_LEVEL: begin
        rd_mux[DATA_W-1:0] = level;
        rd_mux[8 +: DATA_W] = hyst;
      end
      REG_PRE:       rd_mux[ADDR_W-1:0] = pre_len;
      REG_POST:      rd_mux[ADDR_W-1:0] = post_len;
      REG_STATUS:    rd_mux[2:0] = {trig_auto, state};
      REG_TRIG_ADDR: rd_mux[ADDR_W-1:0] = trig_addr;
      default:       rd_mux = '0;
    endcase
  end

  // NOTE: flops use non-blocking assignments so each one samples pre-edge values whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      level    <= '0;
      hyst     <= '0;
      pre_len  <= '0;
      post_len <= '0;
      slope    <= 1'b0;
      auto_en  <= 1'b0;
    end else begin
      if (reg_rd) readdata <= rd_mux;
      if (ctrl_wr) begin
        slope   <= writedata[CTRL_SLOPE];
        auto_en <= writedata[CTRL_AUTO];
      end
      if (reg_wr && (address == REG_LEVEL)) begin
        level <= writedata[DATA_W-1:0];
        hyst  <= writedata[8 +: DATA_W];
      end
      if (reg_wr && (address == REG_PRE))  pre_len  <= writedata[ADDR_W-1:0];
      if (reg_wr && (address == REG_POST)) post_len <= writedata[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      t_int      <= 1'b0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      wr_ptr     <= '0;
      seq_cnt    <= '0;
      auto_cnt   <= '0;
      primed     <= 1'b0;
      force_pend <= 1'b0;
      trig_auto  <= 1'b0;
      trig_addr  <= '0;
    end else begin
      state  <= state_nx;
      // On completion t_int is held one extra clock, so it falls after the last write strobe.
      t_int  <= !abort_req && ((state != ST_IDLE) || (state_nx != ST_IDLE));
      buf_we <= sample_wr;
      if (adc_valid) buf_data <= adc_data;
      if (sample_wr) begin
        buf_addr <= wr_ptr;
        wr_ptr   <= wr_ptr + ADDR_W'(1);
      end

      if (state_nx != state) seq_cnt <= '0;
      else if (adc_valid && ((state == ST_PRE) || (state == ST_POST))) seq_cnt <= seq_inc[ADDR_W-1:0];

      if (state != ST_ARMED) auto_cnt <= '0;
      else if (!auto_expired) auto_cnt <= auto_cnt + AUTO_W'(1);

      if ((state_nx == ST_ARMED) && (state != ST_ARMED)) primed <= 1'b0;
      else if ((state == ST_ARMED) && adc_valid && prime_set) primed <= 1'b1;

      if (state_nx != ST_ARMED) force_pend <= 1'b0;
      else if (force_req && (state == ST_ARMED)) force_pend <= 1'b1;

      if ((state == ST_IDLE) && arm_req && !abort_req) trig_auto <= 1'b0;
      else if (trig_ok) trig_auto <= !fire && !force_pend;

      if (trig_ok) trig_addr <= wr_ptr;
    end
  end

endmodule

// File: tb/tb_dso_trigger_ctrl.sv
// Self-checking bench for dso_trigger_ctrl. The reference model tracks an acquisition as
// sample counts (pre written, trigger seen, post written) and derives the phase from them.
module tb_dso_trigger_ctrl;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int AUTO_TO = 40;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              t_int;

  dso_trigger_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_TO(AUTO_TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .t_int      (t_int)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int   cfg_level, cfg_hyst, cfg_pre, cfg_post;
  bit   cfg_slope, cfg_auto;
  bit   acq_on, trig_seen, primed, force_pend, trig_auto;
  int   n_pre, n_post, armed_clks, trig_addr, wptr;
  bit   exp_we, exp_tint;
  int   exp_addr, exp_data;
  logic [31:0] exp_rd;
  int   stim;
  logic [7:0] ramp;

  task automatic model_reset();
    cfg_level = 0; cfg_hyst = 0; cfg_pre = 0; cfg_post = 0; cfg_slope = 0; cfg_auto = 0;
    acq_on = 0; trig_seen = 0; primed = 0; force_pend = 0; trig_auto = 0;
    n_pre = 0; n_post = 0; armed_clks = 0; trig_addr = 0; wptr = 0;
    exp_we = 0; exp_tint = 0; exp_addr = 0; exp_data = 0; exp_rd = '0;
  endtask

  // 0 idle, 1 pre, 2 armed, 3 post
  function automatic int phase();
    if (!acq_on) return 0;
    if (n_pre < cfg_pre) return 1;
    if (!trig_seen) return 2;
    return 3;
  endfunction

  task automatic model_step();
    int ph, smp, lo, hi;
    bit wr, rd, ctrl, arm, frc, abt, was_on, lvl_fire, auto_ok, trig;
    ph = phase(); was_on = acq_on;
    wr = chipselect && !write_n; rd = chipselect && write_n;
    ctrl = wr && (address == 3'd0);
    arm = ctrl && writedata[0]; frc = ctrl && writedata[3]; abt = ctrl && writedata[4];
    if (rd) begin
      case (address)
        3'd1:    exp_rd = 32'(cfg_hyst * 256 + cfg_level);
        3'd2:    exp_rd = 32'(cfg_pre);
        3'd3:    exp_rd = 32'(cfg_post);
        3'd4:    exp_rd = 32'(int'(trig_auto) * 4 + ph);
        3'd5:    exp_rd = 32'(trig_addr);
        default: exp_rd = '0;
      endcase
    end
    smp = int'(adc_data);
    if (adc_valid) exp_data = smp;
    exp_we = adc_valid && (ph != 0);
    if (exp_we) begin
      exp_addr = wptr;
      if (ph == 2) begin
        lo = (cfg_level - cfg_hyst < 0) ? 0 : cfg_level - cfg_hyst;
        hi = (cfg_level + cfg_hyst > 255) ? 255 : cfg_level + cfg_hyst;
        lvl_fire = primed && (cfg_slope ? (smp <= cfg_level) : (smp >= cfg_level));
        auto_ok = cfg_auto && (armed_clks >= AUTO_TO);
        trig = lvl_fire || force_pend || auto_ok;
        if (trig && !abt) begin
          trig_seen = 1; trig_addr = wptr; trig_auto = !lvl_fire && !force_pend;
        end
        if (cfg_slope ? (smp > hi) : (smp < lo)) primed = 1;
      end
      if (ph == 1) n_pre++;
      if (ph == 3) n_post++;
      wptr = (wptr + 1) % DEPTH;
    end
    if (ph == 2) armed_clks++;
    if (ph == 2 && frc) force_pend = 1;
    if (acq_on && trig_seen && n_post >= cfg_post) acq_on = 0;
    if (abt) acq_on = 0;
    else if (!was_on && arm) begin
      acq_on = 1; n_pre = 0; n_post = 0; trig_seen = 0; primed = 0;
      force_pend = 0; armed_clks = 0; trig_auto = 0;
    end
    exp_tint = !abt && (was_on || acq_on);
    if (ctrl) begin cfg_slope = writedata[1]; cfg_auto = writedata[2]; end
    if (wr && address == 3'd1) begin cfg_level = int'(writedata[7:0]); cfg_hyst = int'(writedata[15:8]); end
    if (wr && address == 3'd2) cfg_pre = int'(writedata[ADDR_W-1:0]);
    if (wr && address == 3'd3) cfg_post = int'(writedata[ADDR_W-1:0]);
  endtask

  task automatic gen_sample();
    case (stim)
      0: begin adc_valid = ($urandom_range(0, 9) < 6); adc_data = 8'($urandom); end
      1: begin adc_valid = 1'b1; adc_data = ramp; ramp = ramp + 8'h10; end
      2: begin adc_valid = 1'b1; adc_data = (adc_data == 8'h7F) ? 8'h81 : 8'h7F; end
      default: begin adc_valid = ~adc_valid; adc_data = 8'h40; end
    endcase
  endtask

  // One clock: model the cycle, let the DUT take the edge, compare 1 ns later.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("buf_we",   32'(buf_we),   32'(exp_we));
    check("buf_addr", 32'(buf_addr), 32'(exp_addr));
    check("buf_data", 32'(buf_data), 32'(exp_data));
    check("t_int",    32'(t_int),    32'(exp_tint));
    check("readdata", readdata,      exp_rd);
    chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    gen_sample();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
  endtask

  task automatic bus_rd(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    step();
  endtask

  function automatic logic [31:0] ctrl_word(input bit arm, input bit frc, input bit abt);
    return {27'd0, abt, frc, cfg_auto, cfg_slope, arm};
  endfunction

  task automatic configure(input int lvl, input int hy, input int pre, input int post,
                           input bit slp, input bit aut);
    bus_wr(3'd1, 32'(hy * 256 + lvl));
    bus_wr(3'd2, 32'(pre));
    bus_wr(3'd3, 32'(post));
    bus_wr(3'd0, {27'd0, 2'b00, aut, slp, 1'b0});
  endtask

  task automatic random_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) bus_wr(3'd0, ctrl_word(0, 1, 0));
    else if (r < 5) bus_wr(3'd0, ctrl_word(0, 0, 1));
    else if (r < 7) bus_wr(3'd0, ctrl_word(1, 0, 0));
    else if (r < 14) bus_rd(3'($urandom_range(0, 7)));
    else step();
  endtask

  task automatic run_until_idle(input int bound, input bit random_ops);
    int n;
    n = 0;
    while ((acq_on || exp_tint) && n < bound) begin
      if (random_ops) random_op();
      else step();
      n++;
    end
    if (n >= bound) check("acq_timeout", 32'd1, 32'd0);
  endtask

  task automatic step_until_phase(input int p, input int bound);
    int n;
    n = 0;
    while (phase() != p && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) check("phase_timeout", 32'(phase()), 32'(p));
  endtask

  initial begin
    stim = 0; ramp = '0;
    model_reset();
    gen_sample();
    #3;
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_t_int", 32'(t_int), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    #9 reset_n = 1'b1;
    for (int a = 0; a < 8; a++) bus_rd(3'(a));

    // Ramp: rising slope around 0x80 with 0x10 hysteresis
    configure(8'h80, 8'h10, 4, 8, 1'b0, 1'b0);
    stim = 1; ramp = '0;
    bus_wr(3'd0, ctrl_word(1, 0, 0));
    run_until_idle(200, 1'b0);
    bus_rd(3'd5);
    bus_rd(3'd4);

    // Hysteresis: falling slope, 0x7F/0x81 never exceeds 0x90, so nothing primes
    stim = 2;
    configure(8'h80, 8'h10, 2, 3, 1'b1, 1'b0);
    bus_wr(3'd0, ctrl_word(1, 0, 0));
    step_until_phase(2, 50);
    repeat (40) step();
    check("hyst_still_busy", 32'(t_int), 32'd1);
    bus_rd(3'd4);
    bus_wr(3'd0, ctrl_word(0, 1, 0));
    run_until_idle(50, 1'b0);

    // Auto timeout with a constant input that primes but never reaches the level
    stim = 3;
    configure(8'h80, 8'h10, 1, 2, 1'b0, 1'b1);
    bus_wr(3'd0, ctrl_word(1, 0, 0));
    run_until_idle(300, 1'b0);
    bus_rd(3'd4);
    check("auto_flag", 32'(readdata[2]), 32'd1);

    // ARM during POST is ignored; ABORT mid-POST ends the acquisition
    stim = 0;
    configure(8'h50, 8'h08, 1, 12, 1'b0, 1'b0);
    bus_wr(3'd0, ctrl_word(1, 0, 0));
    step_until_phase(2, 50);
    bus_wr(3'd0, ctrl_word(0, 1, 0));
    step_until_phase(3, 50);
    repeat (2) step();
    bus_wr(3'd0, ctrl_word(1, 0, 0));
    repeat (2) step();
    bus_wr(3'd0, ctrl_word(0, 0, 1));
    check("abort_t_int", 32'(t_int), 32'd0);
    repeat (5) step();
    bus_rd(3'd4);
    // ARM and ABORT in the same write
    bus_wr(3'd0, ctrl_word(1, 0, 1));
    repeat (3) step();

    // Randomised acquisitions
    for (int i = 0; i < 25; i++) begin
      configure($urandom_range(0, 255), $urandom_range(0, 63), $urandom_range(0, 9),
                $urandom_range(0, 9), 1'($urandom), 1'($urandom));
      bus_wr(3'd0, ctrl_word(1, 0, 0));
      run_until_idle(600, 1'b1);
      bus_rd(3'd5);
    end

    // Asynchronous reset while ARMED
    stim = 3;
    configure(8'hF0, 8'h00, 2, 2, 1'b0, 1'b0);
    bus_wr(3'd0, ctrl_word(1, 0, 0));
    step_until_phase(2, 50);
    bus_rd(3'd2);
    repeat (3) step();
    #3 reset_n = 1'b0;
    #1;
    check("arst_buf_we",   32'(buf_we),   32'd0);
    check("arst_buf_addr", 32'(buf_addr), 32'd0);
    check("arst_buf_data", 32'(buf_data), 32'd0);
    check("arst_t_int",    32'(t_int),    32'd0);
    check("arst_readdata", readdata,      32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold_we", 32'(buf_we), 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) bus_rd(3'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
